// File: rtl/adder_sched_pkg.sv
// adder_sched shared types and constants.
// State encoding, default operand width, stats counter width.
package adder_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int STAT_W    = 16;

endpackage

// File: rtl/adder_sched_if.sv
// Request/response bundle between clients and adder_sched.
// master = client side, slave = scheduler side.
interface adder_sched_if
  import adder_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SWIDTH = WIDTH + 1,
  parameter int IDW    = $clog2(NREQ)
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [SWIDTH-1:0]     rsp_sum;
  logic                  rsp_zero;

  modport master (
    output req_valid, req_x, req_y, req_cin,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_sum, rsp_zero
  );

  modport slave (
    input  req_valid, req_x, req_y, req_cin,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_sum, rsp_zero
  );

endinterface

// File: rtl/adder_sched_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping.
// Pointer storage lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx
);

  // Scan from ptr upward with wrap, take the first asserted request.
  always_comb begin : scan
    int   j;
    logic found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (en && !found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler around one registered add-with-carry unit.
// Optional ADDER_SCHED_STATS_EN adds op_count (completed responses).
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SWIDTH = WIDTH + 1,
  parameter int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  adder_sched_if.slave      bus
`ifdef ADDER_SCHED_STATS_EN
  ,
  output logic [STAT_W-1:0] op_count
`endif
);

  state_t            state;
  state_t            state_nxt;
  logic [IDW-1:0]    ptr;
  logic [WIDTH-1:0]  x_reg;
  logic [WIDTH-1:0]  y_reg;
  logic              cin_reg;
  logic [IDW-1:0]    id_reg;
  logic [IDW-1:0]    rsp_id_reg;
  logic [SWIDTH-1:0] sum_reg;
  logic              zero_reg;
  logic [SWIDTH-1:0] sum;
  logic              arb_en;
  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic              gnt_any;
  logic              rsp_fire;

  assign arb_en   = (state == IDLE) ||
                    ((state == HOLD) && bus.rsp_ready);
  assign gnt_any  = |gnt;
  assign rsp_fire = (state == HOLD) && bus.rsp_ready;
  assign sum      = SWIDTH'(x_reg) + SWIDTH'(y_reg)
                  + SWIDTH'(cin_reg);

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req  (bus.req_valid),
    .ptr  (ptr),
    .en   (arb_en),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept, compute, then hold until consumed.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (gnt_any) state_nxt = CALC;
      CALC: state_nxt = HOLD;
      HOLD: begin
        if (bus.rsp_ready)
          state_nxt = gnt_any ? CALC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: grant is combinational, response from registers.
  always_comb begin
    bus.req_ready = gnt;
    bus.rsp_valid = (state == HOLD);
    bus.rsp_id    = rsp_id_reg;
    bus.rsp_sum   = sum_reg;
    bus.rsp_zero  = zero_reg;
  end

  // Round-robin pointer moves past the winner on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      if (gnt_idx == IDW'(NREQ - 1)) ptr <= '0;
      else                           ptr <= gnt_idx + 1'b1;
    end
  end

  // Operand capture on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg   <= '0;
      y_reg   <= '0;
      cin_reg <= 1'b0;
      id_reg  <= '0;
    end else if (gnt_any) begin
      x_reg   <= bus.req_x[gnt_idx*WIDTH +: WIDTH];
      y_reg   <= bus.req_y[gnt_idx*WIDTH +: WIDTH];
      cin_reg <= bus.req_cin[gnt_idx];
      id_reg  <= gnt_idx;
    end
  end

  // Result stage: sum and zero flag registered during CALC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_reg    <= '0;
      zero_reg   <= 1'b0;
      rsp_id_reg <= '0;
    end else if (state == CALC) begin
      sum_reg    <= sum;
      zero_reg   <= (sum == '0);
      rsp_id_reg <= id_reg;
    end
  end

`ifdef ADDER_SCHED_STATS_EN
  // Saturating count of consumed responses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      op_count <= '0;
    else if (rsp_fire && (op_count != '1))
      op_count <= op_count + 1'b1;
  end
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

endmodule

// File: tb/tb_adder_sched.sv
// Self-checking bench for adder_sched.
// Arithmetic/round-robin reference model plus directed literal checks.
module tb_adder_sched;
  import adder_sched_pkg::*;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 8;
  localparam int SWIDTH = 9;
  localparam int IDW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

`ifdef ADDER_SCHED_STATS_EN
  logic [15:0] op_count;
`endif

  adder_sched #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus)
`ifdef ADDER_SCHED_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model state.
  logic [NREQ-1:0]   gnt_seen;
  int                cyc = 0;
  int                glog_id[$];
  int                glog_cyc[$];
  int                m_ptr = 0;
  int                m_stage = 0;
  int                m_id = 0;
  logic [SWIDTH-1:0] m_sum = '0;
  int                m_cnt = 0;

  // Model: busy slot with 1-cycle compute, round-robin pick.
  initial begin : model
    int                can;
    int                win;
    int                j;
    int                fire;
    int                n_id;
    logic [SWIDTH-1:0] n_sum;
    logic [NREQ-1:0]   exp_rdy;
    gnt_seen = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_ptr = 0; m_stage = 0; m_cnt = 0;
        gnt_seen = '0;
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        continue;
      end
      can = (m_stage == 0) ||
            (m_stage == 2 && bus.rsp_ready);
      win = -1;
      if (can != 0) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (win < 0 && bus.req_valid[j]) win = j;
        end
      end
      exp_rdy = (win >= 0) ? NREQ'(1 << win) : '0;
      chk("req_ready", bus.req_ready, exp_rdy);
      chk("rsp_valid", bus.rsp_valid, m_stage == 2);
      if (m_stage == 2) begin
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_sum", bus.rsp_sum, m_sum);
        chk("rsp_zero", bus.rsp_zero, m_sum == 0);
      end
`ifdef ADDER_SCHED_STATS_EN
      chk("op_count", op_count, m_cnt);
`endif
      gnt_seen = bus.req_ready;
      for (int k = 0; k < NREQ; k++) begin
        if (bus.req_ready[k]) begin
          glog_id.push_back(k);
          glog_cyc.push_back(cyc);
        end
      end
      fire = (m_stage == 2 && bus.rsp_ready) ? 1 : 0;
      n_id = 0;
      n_sum = '0;
      if (win >= 0) begin
        n_id  = win;
        n_sum = SWIDTH'(bus.req_x[win*WIDTH +: WIDTH])
              + SWIDTH'(bus.req_y[win*WIDTH +: WIDTH])
              + SWIDTH'(bus.req_cin[win]);
      end
      @(posedge clk);
      if (fire != 0 && m_cnt < 65535) m_cnt++;
      if (win >= 0) begin
        m_stage = 1;
        m_id    = n_id;
        m_sum   = n_sum;
        m_ptr   = (win + 1) % NREQ;
      end else if (m_stage == 1) begin
        m_stage = 2;
      end else if (fire != 0) begin
        m_stage = 0;
      end
    end
  end

  // Stimulus helpers.
  bit refill = 1'b0;

  task automatic tick();
    @(posedge clk);
    #2;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_seen[i]) begin
        if (refill) begin
          bus.req_x[i*WIDTH +: WIDTH] =
            bus.req_x[i*WIDTH +: WIDTH] + 8'h11;
          bus.req_y[i*WIDTH +: WIDTH] =
            bus.req_y[i*WIDTH +: WIDTH] + 8'h03;
        end else begin
          bus.req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_req(input int i,
                         input logic [7:0] x,
                         input logic [7:0] y,
                         input logic c);
    bus.req_valid[i] = 1'b1;
    bus.req_x[i*WIDTH +: WIDTH] = x;
    bus.req_y[i*WIDTH +: WIDTH] = y;
    bus.req_cin[i] = c;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 12) begin
      tick();
      @(negedge clk);
      n++;
    end
    chk("wait_rsp", bus.rsp_valid, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (bus.req_valid != '0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain", bus.req_valid, 0);
    repeat (4) tick();
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin : stim
    int n;
    int s0;
    logic [SWIDTH-1:0] held;
    int exp_order [5];
    exp_order = '{0, 1, 2, 3, 0};
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_sum", bus.rsp_sum, 0);
    chk("rst_id", bus.rsp_id, 0);
    chk("rst_zero", bus.rsp_zero, 0);
`ifdef ADDER_SCHED_STATS_EN
    chk("rst_op_count", op_count, 0);
`endif
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Single request: FF + 01 + 1.
    bus.rsp_ready = 1'b1;
    set_req(0, 8'hFF, 8'h01, 1'b1);
    @(negedge clk);
    chk("t1_grant", bus.req_ready, 4'b0001);
    tick();
    @(negedge clk);
    chk("t1_calc_valid", bus.rsp_valid, 0);
    chk("t1_calc_ready", bus.req_ready, 0);
    tick();
    @(negedge clk);
    chk("t1_valid", bus.rsp_valid, 1);
    chk("t1_sum", bus.rsp_sum, 9'h101);
    chk("t1_id", bus.rsp_id, 0);
    chk("t1_zero", bus.rsp_zero, 0);
    repeat (2) tick();

    // Zero result from requester 2.
    set_req(2, 8'h00, 8'h00, 1'b0);
    wait_rsp(n);
    chk("t2_latency", n, 2);
    chk("t2_sum", bus.rsp_sum, 0);
    chk("t2_zero", bus.rsp_zero, 1);
    chk("t2_id", bus.rsp_id, 2);
    repeat (2) tick();

    // Wrap: pointer at 3, only requester 0.
    set_req(0, 8'h12, 8'h34, 1'b0);
    wait_rsp(n);
    chk("wrap_id", bus.rsp_id, 0);
    chk("wrap_sum", bus.rsp_sum, 9'h046);
    repeat (2) tick();
    set_req(0, 8'h01, 8'h02, 1'b0);
    set_req(1, 8'h03, 8'h04, 1'b1);
    @(negedge clk);
    chk("wrap_ptr", bus.req_ready, 4'b0010);
    drain();

    // Max operands from requester 3, pointer ends at 0.
    set_req(3, 8'hFF, 8'hFF, 1'b1);
    wait_rsp(n);
    chk("max_sum", bus.rsp_sum, 9'h1FF);
    drain();

    // Fairness: all four held valid.
    refill = 1'b1;
    s0 = glog_id.size();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 8'(i * 16), 8'(i + 5), i[0]);
    n = 0;
    while (glog_id.size() < s0 + 5 && n < 40) begin
      tick();
      n++;
    end
    refill = 1'b0;
    chk("fair_count", glog_id.size() >= s0 + 5, 1);
    if (glog_id.size() >= s0 + 5) begin
      for (int k = 0; k < 5; k++)
        chk("fair_order", glog_id[s0+k], exp_order[k]);
      for (int k = 1; k < 5; k++)
        chk("fair_gap",
            glog_cyc[s0+k] - glog_cyc[s0+k-1], 2);
    end
    drain();

    // Backpressure with requesters 1 and 3 pending.
    bus.rsp_ready = 1'b0;
    set_req(0, 8'h55, 8'h0A, 1'b0);
    wait_rsp(n);
    held = bus.rsp_sum;
    chk("bp_sum", held, 9'h05F);
    tick();
    set_req(1, 8'h20, 8'h30, 1'b1);
    set_req(3, 8'h40, 8'h50, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_no_grant", bus.req_ready, 0);
      chk("bp_hold_sum", bus.rsp_sum, held);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", bus.req_ready, 4'b0010);
    drain();

    // Reset while in CALC.
    set_req(1, 8'h77, 8'h11, 1'b1);
    @(negedge clk);
    chk("rc_grant", bus.req_ready, 4'b0010);
    tick();
    rst_n = 1'b0;
    #1;
    chk("rc_req_ready", bus.req_ready, 0);
    chk("rc_rsp_valid", bus.rsp_valid, 0);
    chk("rc_sum", bus.rsp_sum, 0);
    chk("rc_id", bus.rsp_id, 0);
    chk("rc_zero", bus.rsp_zero, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    chk("rc_quiet", bus.rsp_valid, 0);
`ifdef ADDER_SCHED_STATS_EN
    chk("rc_op_count", op_count, 0);
`endif

    // Mixed traffic with random backpressure.
    for (int c = 0; c < 60; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 2) == 0))
          set_req(i, 8'($urandom), 8'($urandom),
                  1'($urandom));
      end
      bus.rsp_ready = ($urandom_range(0, 2) != 0);
    end
    bus.rsp_ready = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
